regfile_gen2: RTL and testbench
===============================

REGFILE_GEN2 -- requirements
Module: regfile_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, register count (power of 2, >=4); ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter RAND_REG, default 1, index of the random-number register (1..DEPTH-1).
REQ-004 SHALL have parameter RAND_MAX, default 10, upper bound of random values (2..DATA_W-representable); RW = bits to hold RAND_MAX.
REQ-005 SHALL have parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-006 SHALL have parameter LFSR_SEED, default 32'hACE1_0001, nonzero LFSR reset value.
REQ-007 SHALL have port clock  in  1  sole clock, rising edge.
REQ-008 SHALL have port ctrl_reset_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports ctrl_writeEnable in 1, ctrl_writeReg in ADDR_W, data_writeReg in DATA_W: write request.
REQ-010 SHALL have ports ctrl_readRegA, ctrl_readRegB in ADDR_W: read addresses.
REQ-011 SHALL have ports data_readRegA, data_readRegB out DATA_W: combinational read data.
REQ-012 SHALL have ports ctrl_seedLoad in 1, data_seed in 32: LFSR reseed request.
REQ-013 SHALL have port rand_valid out 1: random register holds a fresh, unconsumed value.

Function
REQ-014 Register 0 SHALL read 0 always; writes to it ignored.
REQ-015 Registers other than 0 and RAND_REG SHALL capture data_writeReg on the rising edge when ctrl_writeEnable=1 and ctrl_writeReg selects them.
REQ-016 Reads SHALL be combinational muxes (no tri-states), zero-latency, both ports independent, same address allowed on both.
REQ-017 With BYPASS=1, a read of the register being written that cycle SHALL return data_writeReg (not for 0 or RAND_REG); BYPASS=0 returns old contents.
REQ-018 Writes to RAND_REG SHALL be ignored.
REQ-019 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1, stepping only in state FILL.
REQ-020 Random FSM states: FILL, READY.
REQ-021 FILL: each cycle, candidate = lfsr[RW-1:0]; if 1<=candidate<=RAND_MAX, RAND_REG <= zero-extended candidate, next state READY; LFSR steps regardless.
REQ-022 READY: LFSR holds; rand_valid=1; rand_valid=0 in FILL.
REQ-023 In READY, a read of RAND_REG on port A or B (or both) SHALL return the held value that cycle and move to FILL next cycle; one transition regardless of port count.
REQ-024 Reads of RAND_REG in FILL SHALL return the last accepted value (0 before first acceptance) and not extend FILL.
REQ-025 ctrl_seedLoad=1 SHALL load lfsr <= data_seed (LFSR_SEED if data_seed=0) and force FILL; priority over REQ-021/REQ-023 in the same cycle; RAND_REG unchanged.
REQ-026 RAND_REG value SHALL always lie in 0..RAND_MAX.

Reset
REQ-027 ctrl_reset_n=0 SHALL asynchronously clear all registers to 0, set lfsr=LFSR_SEED, state=FILL, rand_valid=0.
REQ-028 Reset assertion mid-FILL or mid-write SHALL abort it; no partial write survives.
REQ-029 First FILL evaluation SHALL occur on the first rising edge after ctrl_reset_n deasserts.

Structure
REQ-030 Shared package SHALL hold FSM state enum (FILL, READY), LFSR polynomial constant, default seed.
REQ-031 LFSR plus acceptance FSM SHALL be one sub-module, regfile_rand_src, outputting value and valid, taking consume and seed-load inputs.
REQ-032 Storage SHALL be a generated register array; no per-index hand instantiation.

Verification
REQ-033 Reset, write r5=0xDEADBEEF, read A=5,B=0 next cycle -> A=0xDEADBEEF, B=0.
REQ-034 Write r7=0x12 while A=7 same cycle -> A=0x12 (BYPASS=1); with BYPASS=0 -> A=0 that cycle, 0x12 next.
REQ-035 Seed load 0x00000007 -> next edge RAND_REG=7, rand_valid=1; read A=RAND_REG -> 7, rand_valid=0 next cycle.
REQ-036 Seed load 0x0000000F -> candidate 15 rejected, rand_valid stays 0 that edge; RAND_REG keeps prior value; 10,000 cycles of repeated reads -> every value in 1..10, all ten observed.
REQ-037 Write RAND_REG=0x55 and write r0=0xFF -> neither changes; seed load with data_seed=0 -> lfsr=LFSR_SEED.
REQ-038 Drop ctrl_reset_n between clock edges during FILL with r9=0x3 -> r9=0, rand_valid=0 immediately, no clock needed.

Source files
------------

// File: rtl/regfile_gen2_pkg.sv
// Shared definitions for the regfile_gen2 register file.
//   rand_state_t       - state of the random-number acceptance FSM
//   LFSR_POLY          - Galois tap mask for x^32 + x^22 + x^2 + x + 1
//                        (right-shifting form: bits 31, 21, 1, 0)
//   LFSR_DEFAULT_SEED  - default non-zero LFSR reset value
//   lfsr_step()        - one Galois LFSR advance
package regfile_gen2_pkg;

  typedef enum logic {
    RAND_FILL  = 1'b0,
    RAND_READY = 1'b1
  } rand_state_t;

  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_0001;

  // Right-shift Galois step: the bit shifted out folds back into the taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/regfile_rand_src.sv
// Random-value source: 32-bit Galois LFSR plus a FILL/READY acceptance FSM.
//   clock, ctrl_reset_n - rising-edge clock, asynchronous active-low reset
//   consume             - a read of the random register happened this cycle
//   seed_load, seed     - reseed request (seed=0 selects LFSR_SEED)
//   value               - last accepted candidate (0 before the first one)
//   valid               - value is fresh and not yet consumed
//   dbg_state           - current FSM state, for observation only
//
// Handshake: valid is high exactly in READY. A cycle with valid=1 and
// consume=1 hands the value over and returns to FILL on the next edge;
// consume while valid=0 has no effect. seed_load overrides both.
module regfile_rand_src
  import regfile_gen2_pkg::*;
#(
  parameter int          RW        = 4,
  parameter int          RAND_MAX  = 10,
  parameter logic [31:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic          clock,
  input  logic          ctrl_reset_n,
  input  logic          consume,
  input  logic          seed_load,
  input  logic [31:0]   seed,
  output logic [RW-1:0] value,
  output logic          valid,
  output rand_state_t   dbg_state
);

  localparam logic [RW-1:0] MAX_V = RW'(RAND_MAX);

  rand_state_t   state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [RW-1:0] value_q, value_d;
  logic [RW-1:0] candidate;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= RAND_FILL;
      lfsr_q  <= LFSR_SEED;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    value_d   = value_q;
    candidate = lfsr_q[RW-1:0];
    if (seed_load) begin
      // Reseed wins over acceptance and consumption; the held value stays.
      lfsr_d  = (seed == 32'h0) ? LFSR_SEED : seed;
      state_d = RAND_FILL;
    end else begin
      case (state_q)
        RAND_FILL: begin
          lfsr_d = lfsr_step(lfsr_q);
          if ((candidate != '0) && (candidate <= MAX_V)) begin
            value_d = candidate;
            state_d = RAND_READY;
          end
        end
        RAND_READY: begin
          if (consume) state_d = RAND_FILL;
        end
        default: state_d = RAND_FILL;
      endcase
    end
  end

  assign value     = value_q;
  assign valid     = (state_q == RAND_READY);
  assign dbg_state = state_q;

endmodule

// File: rtl/regfile_gen2.sv
// Two-read, one-write register file with a hardwired-zero register 0 and a
// read-only random-number register at index RAND_REG.
//   clock, ctrl_reset_n                 - clock, asynchronous active-low reset
//   ctrl_writeEnable/ctrl_writeReg/
//   data_writeReg                       - write request, captured on the edge
//   ctrl_readRegA/B, data_readRegA/B    - combinational read ports
//   ctrl_seedLoad, data_seed            - LFSR reseed request
//   rand_valid                          - random register holds a fresh value
//   dbg_rand_state                      - random FSM state, for observation
// Reading RAND_REG on either port while rand_valid=1 consumes the value.
module regfile_gen2
  import regfile_gen2_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 32,
  parameter int          RAND_REG  = 1,
  parameter int          RAND_MAX  = 10,
  parameter int          BYPASS    = 1,
  parameter logic [31:0] LFSR_SEED = LFSR_DEFAULT_SEED,
  localparam int         ADDR_W    = $clog2(DEPTH),
  localparam int         RW        = $clog2(RAND_MAX + 1)
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_seedLoad,
  input  logic [31:0]       data_seed,
  output logic              rand_valid,
  output rand_state_t       dbg_rand_state
);

  localparam logic [ADDR_W-1:0] RAND_ADDR = ADDR_W'(RAND_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [RW-1:0]     rand_value;
  logic              consume;
  logic              fwd_ok;

  // Either port addressing the random register counts as one consumption.
  assign consume = (ctrl_readRegA == RAND_ADDR) || (ctrl_readRegB == RAND_ADDR);

  regfile_rand_src #(
    .RW        (RW),
    .RAND_MAX  (RAND_MAX),
    .LFSR_SEED (LFSR_SEED)
  ) u_rand (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .consume      (consume),
    .seed_load    (ctrl_seedLoad),
    .seed         (data_seed),
    .value        (rand_value),
    .valid        (rand_valid),
    .dbg_state    (dbg_rand_state)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else if (i == RAND_REG) begin : g_rand
      assign regs[i] = DATA_W'(rand_value);
    end else begin : g_store
      logic [DATA_W-1:0] q;
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
          q <= '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i))) begin
          q <= data_writeReg;
        end
      end
      assign regs[i] = q;
    end
  end

  // Forwarding only applies to registers that would actually take the write.
  assign fwd_ok = (BYPASS != 0) && ctrl_writeEnable &&
                  (ctrl_writeReg != '0) && (ctrl_writeReg != RAND_ADDR);

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    data_readRegB = regs[ctrl_readRegB];
    if (fwd_ok && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
    if (fwd_ok && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
  end

endmodule

// File: tb/tb_regfile_gen2.sv
module tb_regfile_gen2;
  import regfile_gen2_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic        ctrl_seedLoad = 1'b0;
  logic [31:0] data_seed = '0;

  logic [31:0] data_readRegA, data_readRegB;
  logic        rand_valid;
  rand_state_t dbg_rand_state;

  logic [31:0] nb_readRegA, nb_readRegB;
  logic        nb_rand_valid;
  rand_state_t nb_dbg_rand_state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_gen2 dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_seedLoad    (ctrl_seedLoad),
    .data_seed        (data_seed),
    .rand_valid       (rand_valid),
    .dbg_rand_state   (dbg_rand_state)
  );

  regfile_gen2 #(.BYPASS(0)) dut_nb (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (nb_readRegA),
    .data_readRegB    (nb_readRegB),
    .ctrl_seedLoad    (ctrl_seedLoad),
    .data_seed        (data_seed),
    .rand_valid       (nb_rand_valid),
    .dbg_rand_state   (nb_dbg_rand_state)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd2;
    #2 ctrl_reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++; if (data_readRegA !== 32'h0) begin bad++; $display("FAIL reset_a: got %h want %h", data_readRegA, 32'h0); end
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rand_valid); end
    ctrl_reset_n = 1'b1;
    #1;
    // No FILL evaluation until the first edge after release.
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL reset_no_early_eval: got %b want 0", rand_valid); end
    @(negedge clock); #1;
    // LFSR_SEED low nibble is 1: accepted on the first edge.
    total++; if (rand_valid !== 1'b1) begin bad++; $display("FAIL reset_first_fill: got %b want 1", rand_valid); end
    ctrl_readRegB = 5'd1;
    #1;
    total++; if (data_readRegB !== 32'd1) begin bad++; $display("FAIL reset_first_value: got %h want %h", data_readRegB, 32'd1); end
    ctrl_readRegB = 5'd2;
  endtask

  task automatic test_write_read();
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEAD_BEEF;
    ctrl_readRegA = 5'd2; ctrl_readRegB = 5'd2;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
    #1;
    total++; if (data_readRegA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd_a: got %h want %h", data_readRegA, 32'hDEAD_BEEF); end
    total++; if (data_readRegB !== 32'h0) begin bad++; $display("FAIL wr_rd_b_r0: got %h want %h", data_readRegB, 32'h0); end
    ctrl_readRegB = 5'd5;
    #1;
    total++; if (data_readRegB !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd_same_addr: got %h want %h", data_readRegB, 32'hDEAD_BEEF); end
    ctrl_readRegA = 5'd2; ctrl_readRegB = 5'd2;
  endtask

  task automatic test_bypass();
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h12;
    ctrl_readRegA = 5'd7;
    #1;
    total++; if (data_readRegA !== 32'h12) begin bad++; $display("FAIL bypass_fwd: got %h want %h", data_readRegA, 32'h12); end
    total++; if (nb_readRegA !== 32'h0) begin bad++; $display("FAIL nobypass_old: got %h want %h", nb_readRegA, 32'h0); end
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    #1;
    total++; if (nb_readRegA !== 32'h12) begin bad++; $display("FAIL nobypass_next: got %h want %h", nb_readRegA, 32'h12); end
    total++; if (data_readRegA !== 32'h12) begin bad++; $display("FAIL bypass_next: got %h want %h", data_readRegA, 32'h12); end
    ctrl_readRegA = 5'd2;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h1111_0003;
    @(negedge clock);
    ctrl_writeReg = 5'd4; data_writeReg = 32'h2222_0004;
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4;
    #1;
    total++; if (data_readRegA !== 32'h1111_0003) begin bad++; $display("FAIL b2b_first: got %h want %h", data_readRegA, 32'h1111_0003); end
    total++; if (data_readRegB !== 32'h2222_0004) begin bad++; $display("FAIL b2b_fwd_second: got %h want %h", data_readRegB, 32'h2222_0004); end
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    #1;
    total++; if (data_readRegB !== 32'h2222_0004) begin bad++; $display("FAIL b2b_second: got %h want %h", data_readRegB, 32'h2222_0004); end
    ctrl_readRegA = 5'd2; ctrl_readRegB = 5'd2;
  endtask

  task automatic test_seed7();
    @(negedge clock);
    ctrl_seedLoad = 1'b1; data_seed = 32'h0000_0007;
    @(negedge clock);
    ctrl_seedLoad = 1'b0; data_seed = '0;
    #1;
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL seed7_fill: got %b want 0", rand_valid); end
    @(negedge clock);
    ctrl_readRegA = 5'd1;
    #1;
    total++; if (rand_valid !== 1'b1) begin bad++; $display("FAIL seed7_valid: got %b want 1", rand_valid); end
    total++; if (data_readRegA !== 32'd7) begin bad++; $display("FAIL seed7_value: got %h want %h", data_readRegA, 32'd7); end
    @(negedge clock);
    #1;
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL seed7_consumed: got %b want 0", rand_valid); end
    total++; if (data_readRegA !== 32'd7) begin bad++; $display("FAIL seed7_hold_in_fill: got %h want %h", data_readRegA, 32'd7); end
    ctrl_readRegA = 5'd2;
  endtask

  task automatic test_protected_writes();
    @(negedge clock);
    ctrl_seedLoad = 1'b1; data_seed = 32'h0000_0007;
    @(negedge clock);
    ctrl_seedLoad = 1'b0; data_seed = '0;
    @(negedge clock);
    // READY holding 7; try to overwrite the random register.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h55;
    @(negedge clock);
    ctrl_writeReg = 5'd0; data_writeReg = 32'hFF;
    ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd0;
    #1;
    total++; if (data_readRegA !== 32'd7) begin bad++; $display("FAIL randreg_write_ignored: got %h want %h", data_readRegA, 32'd7); end
    total++; if (data_readRegB !== 32'h0) begin bad++; $display("FAIL r0_no_fwd: got %h want %h", data_readRegB, 32'h0); end
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_readRegA = 5'd2;
    #1;
    total++; if (data_readRegB !== 32'h0) begin bad++; $display("FAIL r0_write_ignored: got %h want %h", data_readRegB, 32'h0); end
    ctrl_seedLoad = 1'b1; data_seed = 32'h0;
    @(negedge clock);
    ctrl_seedLoad = 1'b0;
    @(negedge clock);
    ctrl_readRegB = 5'd1;
    #1;
    // Zero seed selects LFSR_SEED, whose first candidate is 1.
    total++; if (rand_valid !== 1'b1) begin bad++; $display("FAIL seed0_valid: got %b want 1", rand_valid); end
    total++; if (data_readRegB !== 32'd1) begin bad++; $display("FAIL seed0_default: got %h want %h", data_readRegB, 32'd1); end
    ctrl_readRegB = 5'd2;
  endtask

  task automatic test_seed15_stats();
    int          viol = 0;
    logic [10:0] seen = '0;
    logic [31:0] v;
    @(negedge clock);
    ctrl_seedLoad = 1'b1; data_seed = 32'h0000_000F;
    @(negedge clock);
    ctrl_seedLoad = 1'b0; data_seed = '0;
    ctrl_readRegA = 5'd1;
    @(negedge clock);
    #1;
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL seed15_rejected: got %b want 0", rand_valid); end
    total++; if (data_readRegA !== 32'd1) begin bad++; $display("FAIL seed15_prior_kept: got %h want %h", data_readRegA, 32'd1); end
    @(negedge clock);
    #1;
    // 0xF steps to 0x80200004: candidate 4 is accepted.
    total++; if (rand_valid !== 1'b1) begin bad++; $display("FAIL seed15_next_valid: got %b want 1", rand_valid); end
    total++; if (data_readRegA !== 32'd4) begin bad++; $display("FAIL seed15_next_value: got %h want %h", data_readRegA, 32'd4); end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      #1;
      v = data_readRegA;
      if (v > 32'd10) viol++;
      if (rand_valid === 1'b1) begin
        if (v == 32'd0) viol++;
        else if (v <= 32'd10) seen[v[3:0]] = 1'b1;
      end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL rand_range: got %0d out-of-range want 0", viol); end
    total++; if (seen[10:1] !== 10'h3FF) begin bad++; $display("FAIL rand_coverage: got %b want 1111111111", seen[10:1]); end
    ctrl_readRegA = 5'd2;
  endtask

  task automatic test_reset_midfill();
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h3;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_readRegB = 5'd9;
    ctrl_seedLoad = 1'b1; data_seed = 32'h0000_000F;
    #1;
    total++; if (data_readRegB !== 32'h3) begin bad++; $display("FAIL r9_written: got %h want %h", data_readRegB, 32'h3); end
    @(negedge clock);
    ctrl_seedLoad = 1'b0; data_seed = '0;
    #2 ctrl_reset_n = 1'b0;
    #1;
    total++; if (data_readRegB !== 32'h0) begin bad++; $display("FAIL async_r9_clear: got %h want %h", data_readRegB, 32'h0); end
    total++; if (rand_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", rand_valid); end
    total++; if (dbg_rand_state !== RAND_FILL) begin bad++; $display("FAIL async_state: got %0d want %0d", dbg_rand_state, RAND_FILL); end
    // A write presented while reset is held must not land.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h77;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_readRegA = 5'd1;
    #1;
    total++; if (data_readRegB !== 32'h0) begin bad++; $display("FAIL write_under_reset: got %h want %h", data_readRegB, 32'h0); end
    total++; if (data_readRegA !== 32'h0) begin bad++; $display("FAIL randreg_reset: got %h want %h", data_readRegA, 32'h0); end
    ctrl_reset_n = 1'b1;
    ctrl_readRegA = 5'd2; ctrl_readRegB = 5'd2;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_seed7();
    test_protected_writes();
    test_seed15_stats();
    test_reset_midfill();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
